// File: rtl/rr_mux2_stream_pkg.sv
// Shared constants and the round-robin pick used by the two-channel stream arbiter.
package rr_mux2_pkg;

   localparam logic SEL_CH0   = 1'b0;
   localparam logic SEL_CH1   = 1'b1;
   localparam int   DEF_WIDTH = 2;

   // With both requesting, alternate away from the last grant.
   // Otherwise pick the only requester.
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      if (req == 2'b11) return ~last;
      return req[1] ? SEL_CH1 : SEL_CH0;
   endfunction

endpackage

// File: rtl/rr_mux2_stream_if.sv
// Handshake bundle: two valid/ready input channels and one registered output channel.
interface rr_mux2_stream_if
   import rr_mux2_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             in0_valid;
   logic [WIDTH-1:0] in0_data;
   logic             in0_ready;
   logic             in1_valid;
   logic [WIDTH-1:0] in1_data;
   logic             in1_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_sel;
   logic             out_ready;

   // Environment side: produces input words, consumes output words.
   modport master (
      output in0_valid, in0_data, in1_valid, in1_data, out_ready,
      input  in0_ready, in1_ready, out_valid, out_data, out_sel
   );

   // Arbiter side.
   modport slave (
      input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
      output in0_ready, in1_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_mux2_stream_hold_slot.sv
// One-entry holding buffer.
// The ready signal comes only from the registered full flag, so a slot cannot refill
// on the edge it drains.
module hold_slot
   import rr_mux2_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             take,
   output logic [WIDTH-1:0] data,
   output logic             full
);

   assign in_ready = !full;

   // Capture on accept, clear on take.
   // The two cannot coincide: take needs full, and accept needs !full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         data <= '0;
      end else if (in_valid && in_ready) begin
         full <= 1'b1;
         data <= in_data;
      end else if (take) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/rr_mux2_stream.sv
// Two-channel round-robin stream arbiter feeding a registered output.
// out_sel tells the downstream mux which channel out_data came from.
module rr_mux2_stream
   import rr_mux2_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   rr_mux2_stream_if.slave  bus
);

   logic [1:0]            in_valid, in_ready, full, take;
   logic [1:0][WIDTH-1:0] in_data, hold;
   logic                  free, gnt_vld, gnt_sel, last_sel;
   logic                  out_valid, out_sel;
   logic [WIDTH-1:0]      out_data;

   assign in_valid      = {bus.in1_valid, bus.in0_valid};
   assign in_data       = {bus.in1_data, bus.in0_data};
   assign bus.in0_ready = in_ready[0];
   assign bus.in1_ready = in_ready[1];
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign bus.out_sel   = out_sel;

   for (genvar k = 0; k < 2; k++) begin : g_slot
      hold_slot #(.WIDTH(WIDTH)) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid[k]),
         .in_data  (in_data[k]),
         .in_ready (in_ready[k]),
         .take     (take[k]),
         .data     (hold[k]),
         .full     (full[k])
      );
   end

   // Pick a winner whenever the output register can take a word.
   always_comb begin
      free    = !out_valid || bus.out_ready;
      gnt_vld = free && (full != 2'b00);
      gnt_sel = rr_pick(full, last_sel);
      take    = '0;
      if (gnt_vld) take[gnt_sel] = 1'b1;
   end

   // Output register and round-robin history.
   // Data and sel are held when the output goes idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= SEL_CH0;
         last_sel  <= SEL_CH1;
      end else if (free) begin
         if (gnt_vld) begin
            out_valid <= 1'b1;
            out_data  <= hold[gnt_sel];
            out_sel   <= gnt_sel;
            last_sel  <= gnt_sel;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux2_stream.sv
// Directed bench for rr_mux2_stream with hand-computed expected values.
module tb_rr_mux2_stream;

   localparam int WIDTH = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   rr_mux2_stream_if #(.WIDTH(WIDTH)) bus ();

   rr_mux2_stream #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Compare an observed value with an expected one and report any difference.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Step one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in0_valid = 1'b0;
      bus.in1_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [1:0] d, input logic s);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
      chk({tag, "_data"},  32'(bus.out_data),  32'(d));
      chk({tag, "_sel"},   32'(bus.out_sel),   32'(s));
   endtask

   initial begin
      logic [1:0] words [3];
      words[0] = 2'b01;
      words[1] = 2'b10;
      words[2] = 2'b11;

      bus.in0_valid = 1'b0;
      bus.in1_valid = 1'b0;
      bus.in0_data  = '0;
      bus.in1_data  = '0;
      bus.out_ready = 1'b1;

      // Power-on reset state.
      #2;
      chk_out("rst0", 1'b0, 2'b00, 1'b0);
      chk("rst0_rdy0", 32'(bus.in0_ready), 32'd1);
      chk("rst0_rdy1", 32'(bus.in1_ready), 32'd1);
      rst_n = 1'b1;

      // Single channel: one word every two cycles, in order.
      tick();
      bus.in0_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in0_data = words[i];
         tick();
         chk("single_rdy_low", 32'(bus.in0_ready), 32'd0);
         tick();
         chk_out("single", 1'b1, words[i], 1'b0);
         chk("single_rdy_high", 32'(bus.in0_ready), 32'd1);
      end
      bus.in0_valid = 1'b0;
      tick();
      tick();

      // Tie after reset goes to channel 0, then strict alternation.
      do_reset();
      tick();
      bus.in0_valid = 1'b1;
      bus.in0_data  = 2'b00;
      bus.in1_valid = 1'b1;
      bus.in1_data  = 2'b11;
      tick();
      chk("tie_out_idle", 32'(bus.out_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_out("alt", 1'b1, (i % 2 == 0) ? 2'b00 : 2'b11, 1'((i % 2)));
      end
      bus.in0_valid = 1'b0;
      bus.in1_valid = 1'b0;
      tick();
      tick();
      tick();

      // Backpressure: three words buffered, none lost.
      do_reset();
      tick();
      bus.out_ready = 1'b0;
      bus.in0_valid = 1'b1;
      bus.in0_data  = 2'b01;
      tick();
      bus.in0_data  = 2'b10;
      bus.in1_valid = 1'b1;
      bus.in1_data  = 2'b11;
      tick();
      chk_out("bp_first", 1'b1, 2'b01, 1'b0);
      bus.in1_valid = 1'b0;
      tick();
      bus.in0_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk_out("bp_hold", 1'b1, 2'b01, 1'b0);
         chk("bp_rdy0", 32'(bus.in0_ready), 32'd0);
         chk("bp_rdy1", 32'(bus.in1_ready), 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      chk_out("bp_rel1", 1'b1, 2'b11, 1'b1);
      tick();
      chk_out("bp_rel2", 1'b1, 2'b10, 1'b0);
      tick();
      chk("bp_drained", 32'(bus.out_valid), 32'd0);

      // Slot 0 drains while slot 1 accepts on the same edge.
      bus.in0_valid = 1'b1;
      bus.in0_data  = 2'b01;
      tick();
      bus.in0_valid = 1'b0;
      bus.in1_valid = 1'b1;
      bus.in1_data  = 2'b10;
      tick();
      chk_out("sim_g0", 1'b1, 2'b01, 1'b0);
      chk("sim_rdy1", 32'(bus.in1_ready), 32'd0);
      bus.in1_valid = 1'b0;
      tick();
      chk_out("sim_g1", 1'b1, 2'b10, 1'b1);

      // Idle: valid falls, data and sel hold.
      tick();
      chk_out("idle1", 1'b0, 2'b10, 1'b1);
      tick();
      chk_out("idle2", 1'b0, 2'b10, 1'b1);

      // Mid-run asynchronous reset with everything full.
      bus.out_ready = 1'b0;
      bus.in0_valid = 1'b1;
      bus.in0_data  = 2'b01;
      bus.in1_valid = 1'b1;
      bus.in1_data  = 2'b10;
      tick();
      tick();
      tick();
      chk_out("pre_rst", 1'b1, 2'b01, 1'b0);
      chk("pre_rst_rdy0", 32'(bus.in0_ready), 32'd0);
      chk("pre_rst_rdy1", 32'(bus.in1_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, 2'b00, 1'b0);
      chk("async_rst_rdy0", 32'(bus.in0_ready), 32'd1);
      chk("async_rst_rdy1", 32'(bus.in1_ready), 32'd1);
      bus.in0_valid = 1'b0;
      bus.in1_valid = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
